// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - issue sequencer and HI/LO interlock for the iterative mul/div unit
//
// Decodes the ID-stage instruction, launches MULT/MULTU/DIV/DIVU on the shared
// unit, times its latency, pulses the HI/LO write at completion, and stalls any
// HI/LO-touching instruction in ID while an operation is outstanding.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   ID_Op, ID_Funct    - opcode / funct of the instruction in ID
//   ID_Valid           - ID holds a real instruction
//   ID_Kill            - ID instruction is flushed this cycle
//   Ext_Stall          - another unit is holding ID this cycle (blocks issue)
//   PC_WriteEn         - 0 holds the PC
//   IFID_WriteEn       - 0 holds the IF/ID register
//   Stall_flush        - 1 inserts a bubble into ID/EX
//   MD_Start           - registered one-cycle start pulse to the unit
//   MD_IsDiv           - registered: 1 divide, 0 multiply
//   MD_Signed          - registered: 1 signed, 0 unsigned
//   HiLo_WriteEn       - registered one-cycle HI/LO write pulse
//   MD_Busy            - an operation is outstanding (BUSY or WB)

module muldiv_sched #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ID_Op,
  input  logic [5:0] ID_Funct,
  input  logic       ID_Valid,
  input  logic       ID_Kill,
  input  logic       Ext_Stall,
  output logic       PC_WriteEn,
  output logic       IFID_WriteEn,
  output logic       Stall_flush,
  output logic       MD_Start,
  output logic       MD_IsDiv,
  output logic       MD_Signed,
  output logic       HiLo_WriteEn,
  output logic       MD_Busy
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  // Counter preloads: BUSY lasts exactly N cycles, counting N-1 down to 0.
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] count;
  logic             isSpecial;
  logic             mdOp;
  logic             hiloUse;
  logic             issue;
  logic             stallReq;

  // MULT/MULTU/DIV/DIVU are funct 0110xx; MFHI/MTHI/MFLO/MTLO are 0100xx.
  assign isSpecial = (ID_Op == 6'b000000);
  assign mdOp      = isSpecial && (ID_Funct[5:2] == 4'b0110);
  assign hiloUse   = mdOp || (isSpecial && (ID_Funct[5:2] == 4'b0100));

  assign issue    = (state == IDLE) && ID_Valid && mdOp && !ID_Kill && !Ext_Stall;
  assign stallReq = (state != IDLE) && ID_Valid && hiloUse && !ID_Kill;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (issue) nextState = BUSY;
      BUSY:    if (count == '0) nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      MD_Start     <= 1'b0;
      MD_IsDiv     <= 1'b0;
      MD_Signed    <= 1'b0;
      HiLo_WriteEn <= 1'b0;
    end else begin
      state        <= nextState;
      MD_Start     <= issue;
      HiLo_WriteEn <= (state == BUSY) && (count == '0);
      if (issue) begin
        count     <= ID_Funct[1] ? DivLoad : MulLoad;
        MD_IsDiv  <= ID_Funct[1];
        MD_Signed <= ~ID_Funct[0];
      end else if ((state == BUSY) && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  assign PC_WriteEn   = ~stallReq;
  assign IFID_WriteEn = ~stallReq;
  assign Stall_flush  = stallReq;
  assign MD_Busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - scoreboard bench for muldiv_sched (two parameter sets)

module tb_muldiv_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] idOp;
  logic [5:0] idFunct;
  logic       idValid;
  logic       idKill;
  logic       extStall;

  // dut index 0: MUL=4, DIV=32, CNT_W=6; index 1: MUL=1, DIV=3, CNT_W=2
  logic [7:0] got [2];
  logic pcA, ifA, flA, stA, dvA, sgA, hlA, bzA;
  logic pcB, ifB, flB, stB, dvB, sgB, hlB, bzB;

  always #5 clk = ~clk;

  muldiv_sched #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dutA (
    .clk(clk), .reset(rst), .ID_Op(idOp), .ID_Funct(idFunct), .ID_Valid(idValid),
    .ID_Kill(idKill), .Ext_Stall(extStall), .PC_WriteEn(pcA), .IFID_WriteEn(ifA),
    .Stall_flush(flA), .MD_Start(stA), .MD_IsDiv(dvA), .MD_Signed(sgA),
    .HiLo_WriteEn(hlA), .MD_Busy(bzA));

  muldiv_sched #(.MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(2)) dutB (
    .clk(clk), .reset(rst), .ID_Op(idOp), .ID_Funct(idFunct), .ID_Valid(idValid),
    .ID_Kill(idKill), .Ext_Stall(extStall), .PC_WriteEn(pcB), .IFID_WriteEn(ifB),
    .Stall_flush(flB), .MD_Start(stB), .MD_IsDiv(dvB), .MD_Signed(sgB),
    .HiLo_WriteEn(hlB), .MD_Busy(bzB));

  assign got[0] = {pcA, ifA, flA, stA, dvA, sgA, hlA, bzA};
  assign got[1] = {pcB, ifB, flB, stB, dvB, sgB, hlB, bzB};

  // Reference model: an operation is a time stamp. Issued in cycle c with
  // latency N, the unit is busy in cycles c+1..c+N+1, starts in c+1 and
  // writes HI/LO in c+N+1.
  int mulN [2] = '{4, 1};
  int divN [2] = '{32, 3};
  int cyc;
  bit inFlight [2];
  int issueC [2];
  int lenN [2];
  bit isDivM [2];
  bit signedM [2];

  logic [7:0] expQ0 [$];
  logic [7:0] expQ1 [$];
  int total = 0;
  int bad = 0;

  function automatic bit isMdOp(input logic [5:0] op, input logic [5:0] f);
    return (op == 6'd0) && (f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
  endfunction

  function automatic bit isHiLo(input logic [5:0] op, input logic [5:0] f);
    return isMdOp(op, f) ||
           ((op == 6'd0) && (f inside {6'b010000, 6'b010001, 6'b010010, 6'b010011}));
  endfunction

  function automatic bit busyAt(input int k);
    return inFlight[k] && (cyc >= issueC[k] + 1) && (cyc <= issueC[k] + lenN[k] + 1);
  endfunction

  function automatic logic [7:0] expOut(input int k);
    bit b, st, hl, stall;
    b     = busyAt(k);
    st    = b && (cyc == issueC[k] + 1);
    hl    = b && (cyc == issueC[k] + lenN[k] + 1);
    stall = b && idValid && isHiLo(idOp, idFunct) && !idKill;
    return {~stall, ~stall, stall, st, isDivM[k], signedM[k], hl, b};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      inFlight[k] = 0;
      isDivM[k]   = 0;
      signedM[k]  = 0;
    end
  endtask

  // One pipeline cycle: retire the edge with the old inputs, then present new ones.
  task automatic step(input logic [5:0] op, input logic [5:0] f, input logic v,
                      input logic k, input logic e, input logic r);
    @(posedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (!busyAt(d) && idValid && isMdOp(idOp, idFunct) && !idKill && !extStall) begin
          inFlight[d] = 1;
          issueC[d]   = cyc;
          lenN[d]     = (idFunct == 6'b011010 || idFunct == 6'b011011) ? divN[d] : mulN[d];
          isDivM[d]   = (idFunct == 6'b011010 || idFunct == 6'b011011);
          signedM[d]  = (idFunct == 6'b011000 || idFunct == 6'b011010);
        end else if (inFlight[d] && cyc > issueC[d] + lenN[d] + 1) begin
          inFlight[d] = 0;
        end
      end
    end
    cyc++;
    #1;
    idOp = op; idFunct = f; idValid = v; idKill = k; extStall = e; rst = r;
    if (r) modelReset();
    expQ0.push_back(expOut(0));
    expQ1.push_back(expOut(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold(input logic [5:0] f, input int n);
    for (int i = 0; i < n; i++) step(6'd0, f, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (expQ0.size() > 0) begin
      e = expQ0.pop_front();
      total++;
      if (got[0] !== e) begin
        bad++;
        $display("FAIL outA cyc=%0d got=%b want=%b", cyc, got[0], e);
      end
    end
    if (expQ1.size() > 0) begin
      e = expQ1.pop_front();
      total++;
      if (got[1] !== e) begin
        bad++;
        $display("FAIL outB cyc=%0d got=%b want=%b", cyc, got[1], e);
      end
    end
  end

  logic [5:0] pool [12] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011,
                            6'b010000, 6'b010001, 6'b010010, 6'b010011,
                            6'b100000, 6'b100001, 6'b000000, 6'b101010};

  initial begin
    cyc = 0;
    rst = 1'b1; idOp = '0; idFunct = '0; idValid = 1'b0; idKill = 1'b0; extStall = 1'b0;
    modelReset();
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // MULT then idle
    hold(6'b011000, 1);
    idle(8);
    // DIVU followed by a dependent MFLO held in ID
    hold(6'b011011, 1);
    hold(6'b010010, 40);
    idle(3);
    // DIV, ADD in shadow, MULTU waiting for IDLE
    hold(6'b011010, 1);
    hold(6'b100000, 1);
    hold(6'b011001, 40);
    idle(8);
    // MULT then dependent MFHI
    hold(6'b011000, 1);
    hold(6'b010000, 6);
    idle(3);
    // Ext_Stall blocks issue for 2 cycles
    step(6'd0, 6'b011010, 1'b1, 1'b0, 1'b1, 1'b0);
    step(6'd0, 6'b011010, 1'b1, 1'b0, 1'b1, 1'b0);
    hold(6'b011010, 1);
    idle(36);
    // Killed DIV never issues; killed MFHI is never stalled
    step(6'd0, 6'b011010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(6'd0, 6'b011010, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Async reset mid-DIV (count=10 in cycle 22), then a fresh MULT
    hold(6'b011010, 1);
    idle(21);
    step(6'd0, 6'b010000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(6'd0, 6'b010000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(6'd0, 6'b010000, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(40);
    hold(6'b011000, 1);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op, f;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
      step(op, f, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 199) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    total++;
    if (expQ0.size() + expQ1.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expQ0.size() + expQ1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
